// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame width, transmit-arbiter FSM states and ID width helper.
package uart_pkg;

    localparam int unsigned UART_DBIT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } arb_state_e;

    // Requester index width; never narrower than one bit.
    function automatic int unsigned id_w(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from i_rr_last+1 with wrap.
module uart_rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_rr_last,
    output logic [ID_W-1:0]  o_winner,
    output logic             o_any_req
);

    logic [ID_W-1:0] w_idx;

    always_comb begin
        o_winner  = '0;
        o_any_req = 1'b0;
        w_idx     = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            w_idx = ID_W'((32'(i_rr_last) + i) % N_REQ);
            if (!o_any_req && i_req[w_idx]) begin
                o_winner  = w_idx;
                o_any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N_REQ requesters; grant is held for a whole packet.
// Define UART_ARB_TIMEOUT_EN to release an owner that stalls TIMEOUT_CYC cycles in LOAD.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned DBIT        = UART_DBIT,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DBIT-1:0]     req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      tx_start,
    output logic [DBIT-1:0]           tx_din,
    input  logic                      tx_done_tick,
    output logic [id_w(N_REQ)-1:0]    grant_id,
    output logic                      busy,
    output logic                      timeout_tick
);

    localparam int unsigned ID_W = id_w(N_REQ);

    if (N_REQ < 2) begin : g_bad_nreq
        $error("uart_tx_arbiter: N_REQ must be at least 2");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT_CYC must be at least 1");
    end

    arb_state_e      r_state;
    logic [ID_W-1:0] r_rr_last;
    logic            r_last_q;

    logic [ID_W-1:0] w_winner;
    logic            w_any_req;
    logic            w_grant_valid;
    logic            w_grant_last;
    logic [DBIT-1:0] w_grant_data;
    logic            w_handshake;
    logic            w_stall_expire;

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .i_req     (req_valid),
        .i_rr_last (r_rr_last),
        .o_winner  (w_winner),
        .o_any_req (w_any_req)
    );

    assign w_grant_valid = req_valid[grant_id];
    assign w_grant_last  = req_last[grant_id];
    assign w_grant_data  = req_data[32'(grant_id) * DBIT +: DBIT];
    assign w_handshake   = (r_state == LOAD) && w_grant_valid;

    // Only the owner sees ready, and only while its byte can be loaded.
    always_comb begin
        req_ready = '0;
        if (r_state == LOAD) begin
            req_ready[grant_id] = w_grant_valid;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] r_stall_cnt;

    assign w_stall_expire = (r_state == LOAD) && !w_grant_valid &&
                            (r_stall_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
        end else if ((r_state != LOAD) || w_grant_valid || w_stall_expire) begin
            r_stall_cnt <= '0;
        end else begin
            r_stall_cnt <= r_stall_cnt + TO_W'(1);
        end
    end
`else
    assign w_stall_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_rr_last    <= ID_W'(N_REQ - 1);
            r_last_q     <= 1'b0;
            tx_start     <= 1'b0;
            tx_din       <= '0;
            grant_id     <= '0;
            busy         <= 1'b0;
            timeout_tick <= 1'b0;
        end else begin
            tx_start     <= 1'b0;
            timeout_tick <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        grant_id <= w_winner;
                        busy     <= 1'b1;
                        r_state  <= LOAD;
                    end
                end
                LOAD: begin
                    if (w_handshake) begin
                        tx_din   <= w_grant_data;
                        r_last_q <= w_grant_last;
                        tx_start <= 1'b1;
                        r_state  <= SEND;
                    end else if (w_stall_expire) begin
                        // Abandon the partial packet and let others in.
                        timeout_tick <= 1'b1;
                        r_rr_last    <= grant_id;
                        busy         <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                SEND: begin
                    if (tx_done_tick) begin
                        if (r_last_q) begin
                            r_rr_last <= grant_id;
                            busy      <= 1'b0;
                            r_state   <= IDLE;
                        end else begin
                            r_state <= LOAD;
                        end
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: packet-level round-robin model, scripted scenarios and random packet mixes.
// Scenario 6 follows UART_ARB_TIMEOUT_EN the same way the design does.
module tb_uart_tx_arbiter;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int TO   = 16;
    localparam int IDW  = 2;
    localparam int MAXB = 64;

    logic            clk;
    logic            reset_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            tx_start;
    logic [DW-1:0]   tx_din;
    logic            tx_done_tick;
    logic [IDW-1:0]  grant_id;
    logic            busy;
    logic            timeout_tick;

    int total;
    int bad;

    logic [7:0]   pdata [N][MAXB];
    logic         plast [N][MAXB];
    int           wr [N];
    int           rd [N];
    logic [N-1:0] stall;

    logic [7:0] obs_data [N*MAXB];
    int         obs_id   [N*MAXB];
    int         n_obs;
    int         done_cnt;
    int         done_delay;
    int         ticks;

    logic           s_busy;
    logic           s_start;
    logic           s_tout;
    logic [IDW-1:0] s_gid;
    logic [N-1:0]   s_ready;

    uart_tx_arbiter #(
        .N_REQ       (N),
        .DBIT        (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .tx_done_tick (tx_done_tick),
        .grant_id     (grant_id),
        .busy         (busy),
        .timeout_tick (timeout_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each requester presents its next queued byte unless stalled.
    task automatic update_inputs();
        for (int i = 0; i < N; i++) begin
            if (rd[i] < wr[i] && !stall[i]) begin
                req_valid[i]            = 1'b1;
                req_data[i*DW +: DW]    = pdata[i][rd[i]];
                req_last[i]             = plast[i][rd[i]];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    endtask

    task automatic post_byte(input int r, input logic [7:0] d, input logic l);
        if (wr[r] < MAXB) begin
            pdata[r][wr[r]] = d;
            plast[r][wr[r]] = l;
            wr[r]++;
        end
        update_inputs();
    endtask

    task automatic clear_bench();
        for (int i = 0; i < N; i++) begin
            rd[i] = 0;
            wr[i] = 0;
        end
        stall        = '0;
        req_valid    = '0;
        req_data     = '0;
        req_last     = '0;
        tx_done_tick = 1'b0;
        done_cnt     = -1;
        n_obs        = 0;
        ticks        = 0;
    endtask

    // One clock: sample outputs at negedge, then act as requesters and as uart_tx after the edge.
    task automatic step();
        logic [N-1:0] acc;
        @(negedge clk);
        s_busy  = busy;
        s_start = tx_start;
        s_tout  = timeout_tick;
        s_gid   = grant_id;
        s_ready = req_ready;
        if (tx_start) begin
            if (n_obs < N*MAXB) begin
                obs_data[n_obs] = tx_din;
                obs_id[n_obs]   = int'(grant_id);
            end
            n_obs++;
            done_cnt = done_delay;
        end
        acc = req_ready & req_valid;
        @(posedge clk);
        #1;
        tx_done_tick = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) rd[i]++;
        end
        if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) begin
                tx_done_tick = 1'b1;
                done_cnt     = -1;
                ticks++;
            end
        end
        update_inputs();
    endtask

    function automatic bit pending();
        bit p;
        p = s_busy || (done_cnt >= 0) || tx_done_tick;
        for (int i = 0; i < N; i++) begin
            if (rd[i] < wr[i]) p = 1'b1;
        end
        return p;
    endfunction

    task automatic drain(input int budget, output bit expired);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (pending() && k < budget);
        expired = pending();
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        clear_bench();
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_bench();
        done_delay = 1;
        #1;
        total++; if (tx_start !== 1'b0)     begin bad++; $display("FAIL rst_tx_start: got %b want 0", tx_start); end
        total++; if (tx_din !== 8'h00)      begin bad++; $display("FAIL rst_tx_din: got %h want 00", tx_din); end
        total++; if (grant_id !== 2'd0)     begin bad++; $display("FAIL rst_grant_id: got %0d want 0", grant_id); end
        total++; if (busy !== 1'b0)         begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (req_ready !== 4'h0)    begin bad++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
        total++; if (timeout_tick !== 1'b0) begin bad++; $display("FAIL rst_timeout_tick: got %b want 0", timeout_tick); end
        apply_reset();
    endtask

    task automatic test_single_packet();
        logic [7:0] ed [3];
        bit started;
        bit held_ok;
        int k;
        ed = '{8'hA5, 8'h5A, 8'hFF};
        apply_reset();
        done_delay = 20;
        post_byte(1, 8'hA5, 1'b0);
        post_byte(1, 8'h5A, 1'b0);
        post_byte(1, 8'hFF, 1'b1);
        started = 1'b0;
        held_ok = 1'b1;
        k = 0;
        while (ticks < 3 && k < 300) begin
            step();
            k++;
            if (s_busy === 1'b1) started = 1'b1;
            if (started && (s_busy !== 1'b1 || s_gid !== 2'd1)) held_ok = 1'b0;
        end
        total++; if (ticks !== 3)      begin bad++; $display("FAIL pkt1_ticks: got %0d want 3", ticks); end
        total++; if (!started || !held_ok) begin bad++; $display("FAIL pkt1_busy_grant_held: started=%b held=%b want 1 1", started, held_ok); end
        step();
        step();
        total++; if (s_busy !== 1'b0)  begin bad++; $display("FAIL pkt1_busy_after: got %b want 0", s_busy); end
        total++; if (n_obs !== 3)      begin bad++; $display("FAIL pkt1_starts: got %0d want 3", n_obs); end
        for (int e = 0; e < 3; e++) begin
            total++;
            if (obs_data[e] !== ed[e] || obs_id[e] !== 1) begin
                bad++; $display("FAIL pkt1_byte%0d: got %h/id%0d want %h/id1", e, obs_data[e], obs_id[e], ed[e]);
            end
        end
    endtask

    task automatic test_all_four();
        logic [7:0] ed [5];
        int eid [5];
        bit expired;
        ed  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20};
        eid = '{0, 1, 2, 3, 0};
        apply_reset();
        done_delay = 3;
        for (int i = 0; i < N; i++) post_byte(i, 8'(8'h10 + i), 1'b1);
        post_byte(0, 8'h20, 1'b1);
        drain(400, expired);
        total++; if (expired !== 1'b0) begin bad++; $display("FAIL rr4_drain: got expired=%b want 0", expired); end
        total++; if (n_obs !== 5)      begin bad++; $display("FAIL rr4_count: got %0d want 5", n_obs); end
        for (int e = 0; e < 5; e++) begin
            total++;
            if (obs_data[e] !== ed[e] || obs_id[e] !== eid[e]) begin
                bad++; $display("FAIL rr4_order%0d: got %h/id%0d want %h/id%0d", e, obs_data[e], obs_id[e], ed[e], eid[e]);
            end
        end
    endtask

    task automatic test_packet_lock();
        logic [7:0] ed [4];
        int eid [4];
        int k;
        int ticks_at_ready0;
        ed  = '{8'hC1, 8'hC2, 8'hC3, 8'h0D};
        eid = '{2, 2, 2, 0};
        apply_reset();
        done_delay = 4;
        post_byte(2, 8'hC1, 1'b0);
        post_byte(2, 8'hC2, 1'b0);
        post_byte(2, 8'hC3, 1'b1);
        k = 0;
        while (n_obs < 1 && k < 50) begin
            step();
            k++;
        end
        post_byte(0, 8'h0D, 1'b1);
        ticks_at_ready0 = -1;
        k = 0;
        do begin
            step();
            k++;
            if (s_ready[0] === 1'b1 && ticks_at_ready0 < 0) ticks_at_ready0 = ticks;
        end while (pending() && k < 400);
        total++; if (pending())             begin bad++; $display("FAIL lock_drain: got pending=1 want 0"); end
        total++; if (ticks_at_ready0 !== 3) begin bad++; $display("FAIL lock_ready0: got ticks=%0d want 3", ticks_at_ready0); end
        total++; if (n_obs !== 4)           begin bad++; $display("FAIL lock_count: got %0d want 4", n_obs); end
        for (int e = 0; e < 4; e++) begin
            total++;
            if (obs_data[e] !== ed[e] || obs_id[e] !== eid[e]) begin
                bad++; $display("FAIL lock_order%0d: got %h/id%0d want %h/id%0d", e, obs_data[e], obs_id[e], ed[e], eid[e]);
            end
        end
    endtask

    task automatic test_stray_tick();
        bit quiet;
        bit held;
        bit expired;
        apply_reset();
        done_delay = 2;
        tx_done_tick = 1'b1;
        quiet = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            if (s_busy !== 1'b0 || s_start !== 1'b0) quiet = 1'b0;
        end
        total++; if (!quiet) begin bad++; $display("FAIL stray_idle: got busy/start activity want none"); end
        post_byte(1, 8'h3C, 1'b1);
        step();
        stall[1] = 1'b1;
        update_inputs();
        tx_done_tick = 1'b1;
        held = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            if (s_busy !== 1'b1 || s_gid !== 2'd1 || s_start !== 1'b0 || s_ready !== 4'h0) held = 1'b0;
        end
        total++; if (!held) begin bad++; $display("FAIL stray_load: got state change want LOAD held for 1"); end
        stall[1] = 1'b0;
        update_inputs();
        drain(100, expired);
        total++; if (expired !== 1'b0) begin bad++; $display("FAIL stray_drain: got expired=%b want 0", expired); end
        total++;
        if (n_obs !== 1 || obs_data[0] !== 8'h3C || obs_id[0] !== 1) begin
            bad++; $display("FAIL stray_byte: got n=%0d %h/id%0d want 1 3c/id1", n_obs, obs_data[0], obs_id[0]);
        end
    endtask

    task automatic test_async_reset();
        bit expired;
        int k;
        apply_reset();
        done_delay = 3;
        post_byte(0, 8'h01, 1'b1);
        drain(100, expired);
        done_delay = 20;
        post_byte(1, 8'hB1, 1'b0);
        post_byte(1, 8'hB2, 1'b1);
        k = 0;
        while (n_obs < 2 && k < 50) begin
            step();
            k++;
        end
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (tx_start !== 1'b0)     begin bad++; $display("FAIL arst_tx_start: got %b want 0", tx_start); end
        total++; if (tx_din !== 8'h00)      begin bad++; $display("FAIL arst_tx_din: got %h want 00", tx_din); end
        total++; if (grant_id !== 2'd0)     begin bad++; $display("FAIL arst_grant_id: got %0d want 0", grant_id); end
        total++; if (busy !== 1'b0)         begin bad++; $display("FAIL arst_busy: got %b want 0", busy); end
        total++; if (req_ready !== 4'h0)    begin bad++; $display("FAIL arst_req_ready: got %b want 0000", req_ready); end
        total++; if (timeout_tick !== 1'b0) begin bad++; $display("FAIL arst_timeout_tick: got %b want 0", timeout_tick); end
        clear_bench();
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        done_delay = 3;
        post_byte(2, 8'h22, 1'b1);
        post_byte(0, 8'h0A, 1'b1);
        drain(200, expired);
        total++; if (expired !== 1'b0) begin bad++; $display("FAIL arst_drain: got expired=%b want 0", expired); end
        total++;
        if (n_obs !== 2 || obs_id[0] !== 0 || obs_data[0] !== 8'h0A || obs_id[1] !== 2 || obs_data[1] !== 8'h22) begin
            bad++; $display("FAIL arst_order: got n=%0d id%0d,id%0d want n=2 id0,id2", n_obs, obs_id[0], obs_id[1]);
        end
    endtask

    task automatic test_timeout();
        int k;
`ifdef UART_ARB_TIMEOUT_EN
        int fire_at;
        int fires;
        bit expired;
`else
        bit quiet;
`endif
        apply_reset();
        done_delay = 3;
        post_byte(3, 8'h33, 1'b0);
        k = 0;
        while (ticks < 1 && k < 50) begin
            step();
            k++;
        end
        post_byte(0, 8'h44, 1'b1);
`ifdef UART_ARB_TIMEOUT_EN
        fire_at = -1;
        fires   = 0;
        for (int c = 1; c <= TO + 10; c++) begin
            step();
            if (s_tout === 1'b1) begin
                fires++;
                if (fire_at < 0) fire_at = c;
            end
        end
        total++; if (fire_at !== TO + 2) begin bad++; $display("FAIL to_fire_cycle: got %0d want %0d", fire_at, TO + 2); end
        total++; if (fires !== 1)        begin bad++; $display("FAIL to_pulse_count: got %0d want 1", fires); end
        drain(200, expired);
        total++; if (expired !== 1'b0)   begin bad++; $display("FAIL to_drain: got expired=%b want 0", expired); end
        total++;
        if (n_obs !== 2 || obs_id[1] !== 0 || obs_data[1] !== 8'h44) begin
            bad++; $display("FAIL to_next_grant: got n=%0d %h/id%0d want 2 44/id0", n_obs, obs_data[1], obs_id[1]);
        end
`else
        quiet = 1'b1;
        for (int c = 0; c < TO + 24; c++) begin
            step();
            if (s_tout !== 1'b0 || s_gid !== 2'd3 || s_busy !== 1'b1 || s_ready[0] !== 1'b0) quiet = 1'b0;
        end
        total++; if (!quiet)     begin bad++; $display("FAIL to_hold: got release/timeout activity want grant held by 3"); end
        total++; if (n_obs !== 1) begin bad++; $display("FAIL to_hold_count: got %0d want 1", n_obs); end
`endif
    endtask

    // Random packet mixes against a packet-level round-robin model.
    task automatic test_random_rr();
        int npk [N];
        int plen [N][2];
        logic [7:0] pb [N][2][4];
        logic [7:0] ed [N*8];
        int eid [N*8];
        int served [N];
        int n_exp;
        int cur;
        int found;
        bit expired;
        for (int r = 0; r < 4; r++) begin
            apply_reset();
            done_delay = int'($urandom_range(1, 4));
            for (int i = 0; i < N; i++) begin
                npk[i]    = int'($urandom_range(0, 2));
                served[i] = 0;
                for (int p = 0; p < npk[i]; p++) begin
                    plen[i][p] = int'($urandom_range(1, 4));
                    for (int b = 0; b < plen[i][p]; b++) begin
                        pb[i][p][b] = 8'($urandom);
                        post_byte(i, pb[i][p][b], b == plen[i][p] - 1);
                    end
                end
            end
            n_exp = 0;
            cur   = N - 1;
            forever begin
                found = -1;
                for (int s = 1; s <= N; s++) begin
                    if (found < 0 && served[(cur + s) % N] < npk[(cur + s) % N]) found = (cur + s) % N;
                end
                if (found < 0) break;
                for (int b = 0; b < plen[found][served[found]]; b++) begin
                    ed[n_exp]  = pb[found][served[found]][b];
                    eid[n_exp] = found;
                    n_exp++;
                end
                served[found]++;
                cur = found;
            end
            drain(2000, expired);
            total++; if (expired !== 1'b0) begin bad++; $display("FAIL rnd%0d_drain: got expired=%b want 0", r, expired); end
            total++; if (n_obs !== n_exp)  begin bad++; $display("FAIL rnd%0d_count: got %0d want %0d", r, n_obs, n_exp); end
            for (int e = 0; e < n_exp; e++) begin
                total++;
                if (obs_data[e] !== ed[e] || obs_id[e] !== eid[e]) begin
                    bad++; $display("FAIL rnd%0d_byte%0d: got %h/id%0d want %h/id%0d", r, e, obs_data[e], obs_id[e], ed[e], eid[e]);
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_packet();
        test_all_four();
        test_packet_lock();
        test_stray_tick();
        test_async_reset();
        test_timeout();
        test_random_rr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
